axi_rd_responder: RTL
=====================

Name: axi_rd_responder

Overview:
- Synthesizable AXI read-channel responder (AR slave, R slave) sitting at the memory end of the prefetcher path.
- Used as the DDR-side stand-in during prefetcher bring-up. Connects to the prefetcher's m_ar_* / m_r_* master ports.
- Accepts burst read requests, queues them in order, and returns len+1 data beats per request after a programmable latency.
- Beat data is an address-derived pattern, so every beat is checkable without a memory array.

Parameters:
- ADDR_BITS, 64, request address width.
- BURST_LEN_WIDTH, 8, AXI len field width (beats = len+1).
- TID_WIDTH, 4, transaction ID width.
- LOG_BLOCK_DATA_BYTES, 6, log2 of bytes per beat. BLOCK_DATA_SIZE_BITS = 8<<LOG_BLOCK_DATA_BYTES; it must be a multiple of ADDR_BITS.
- LOG_REQ_QUEUE, 2, log2 of request queue depth.
- RESP_LATENCY, 4, cycles from request eligibility to first beat valid; must be >=1.

Ports:
- clk  in  1  clock.
- resetN  in  1  synchronous active-low reset.
- en  in  1  responder enable.
- s_ar_valid  in  1  AR valid.
- s_ar_ready  out  1  AR ready.
- s_ar_len  in  BURST_LEN_WIDTH  burst length-1.
- s_ar_addr  in  ADDR_BITS  first-beat byte address.
- s_ar_id  in  TID_WIDTH  request ID.
- s_r_valid  out  1  R valid.
- s_r_ready  in  1  R ready.
- s_r_last  out  1  last beat of burst.
- s_r_data  out  BLOCK_DATA_SIZE_BITS  beat data.
- s_r_id  out  TID_WIDTH  ID of the burst being returned.
- reqCnt  out  LOG_REQ_QUEUE+1  queued, not-yet-completed requests.

Behaviour:
- Reset (resetN=0 at a clk edge):
  - Queue emptied; state IDLE; beat and latency counters cleared.
  - Next cycle outputs: s_ar_ready=0, s_r_valid=0, s_r_last=0, s_r_data=0, s_r_id=0, reqCnt=0.
  - s_ar_ready may rise the cycle after resetN deasserts.
  - Reset mid-burst abandons the burst with no further beats.
- AR channel:
  - s_ar_ready = en & ~full.
  - A handshake (valid & ready) pushes {addr,len,id}.
  - No same-cycle pop-to-push passthrough when full.
- Ordering: strictly in order; one burst active at a time. The queue entry pops on the handshake of its last beat. reqCnt counts pushes minus pops.
- FSM: IDLE -> WAIT -> BURST.
  - IDLE: queue non-empty and en=1 -> WAIT, latency counter loaded.
  - WAIT: counts down; at expiry -> BURST.
  - BURST: beat index 0..len. Last-beat handshake -> WAIT if another entry is queued and en=1, else IDLE.
- Latency: first beat of burst k has s_r_valid=1 exactly RESP_LATENCY cycles after max(AR handshake cycle of k, last-beat handshake cycle of burst k-1).
  - Example: empty queue, handshake at cycle T -> s_r_valid at T+RESP_LATENCY.
- Beat address: beatAddr = addr + (beat << LOG_BLOCK_DATA_BYTES), modulo 2^ADDR_BITS (INCR burst, wraps silently).
- Beat data: s_r_data = beatAddr replicated BLOCK_DATA_SIZE_BITS/ADDR_BITS times; copy 0 sits at the most-significant position.
- s_r_last = 1 exactly when beat == len. s_r_id = the entry's id for every beat.
- R handshake:
  - Once asserted, s_r_valid stays high and data/last/id stay stable until s_r_ready.
  - Without stalls, beats go back-to-back while s_r_ready=1.
- en=0 (AR side): s_ar_ready drops immediately.
- en=0 (R side): an active burst completes, but no new burst leaves IDLE/WAIT. The WAIT counter freezes and resumes when en returns to 1.
- len=0: single beat with s_r_last=1.
- Full queue: s_ar_ready=0 until the pop cycle's next edge.
- Simultaneous push and last-beat pop: reqCnt unchanged.

Optional Feature:
- Macro: AXI_RD_RESP_STALL_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 on reset, advancing every cycle.
  - In BURST, when s_r_valid=0 and lfsr[7]=1, the next beat is withheld that cycle.
  - An asserted valid is never dropped.
  - The first-beat latency becomes >= RESP_LATENCY.
- Undefined: no LFSR; timing exactly as stated above.

Decomposition:
- Package axi_rd_pkg holds:
  - typedef ar_req_t {addr, len, id};
  - LFSR seed and tap constants;
  - state enum rd_state_t {IDLE, WAIT, BURST}.
- One sub-module, axi_req_fifo: parameterized-depth synchronous FIFO of ar_req_t with full, empty, count and registered head output.

Test Plan:
- After reset, AR addr=0x1000 len=3 id=5 at cycle T, s_r_ready=1 -> beats at T+4..T+7. Beat data = replicated 0x1000, 0x1040, 0x1080, 0x10C0; id=5 on every beat; last only on the 4th beat.
- Four back-to-back ARs with len=0 and s_r_ready=0 -> s_ar_ready=0 on the 5th attempt and reqCnt=4. Raising ready drains them in order; consecutive first beats are spaced RESP_LATENCY cycles after each prior last-beat handshake.
- s_r_ready toggling 1,0,0,1 mid-burst -> valid, data and last held stable through the stall; no beat lost or duplicated.
- addr=0xFFFF_FFFF_FFFF_FFC0 with len=1 -> beat 1 address wraps to 0x0.
- resetN=0 during beat 2 of a len=7 burst -> next cycle s_r_valid=0 and reqCnt=0; a fresh AR then behaves exactly as the first scenario.
- en=0 during WAIT -> no beat while en=0; the first beat arrives remaining-count cycles after en returns to 1. A burst already in progress completes despite en=0.

Source files
------------

// File: rtl/axi_rd_responder_pkg.sv
// Shared types and constants for the AXI read responder and its request FIFO.
// The stall LFSR constants are consumed only when AXI_RD_RESP_STALL_EN is defined.
package axi_rd_pkg;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_req_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 of a Fibonacci LFSR, bit 7 being tap 8
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } rd_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axi_rd_responder_req_fifo.sv
// In-order request queue for the read responder: synchronous FIFO with a
// registered head entry, full/empty flags and an occupancy count.
module axi_req_fifo
  import axi_rd_pkg::*;
#(
  parameter type         T         = ar_req_t,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               push,
  input  T                   din,
  input  logic               pop,
  output T                   head,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  T                     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH-1:0] rd_next;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Head follows the next stored entry, or the incoming one when the queue
      // is (or is about to be) otherwise empty.
      if (do_pop && (count > (LOG_DEPTH+1)'(1))) begin
        head <= mem[rd_next];
      end else if (do_push && (empty || do_pop)) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI read-channel responder: queues AR bursts and returns address-pattern beats
// after RESP_LATENCY cycles. Optional random R stalls via AXI_RD_RESP_STALL_EN.
module axi_rd_responder
  import axi_rd_pkg::*;
#(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 4,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_REQ_QUEUE        = 2,
  parameter int RESP_LATENCY         = 4,
  localparam int BLOCK_DATA_SIZE_BITS = 8 << LOG_BLOCK_DATA_BYTES
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            en,
  input  logic                            s_ar_valid,
  output logic                            s_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0]      s_ar_len,
  input  logic [ADDR_BITS-1:0]            s_ar_addr,
  input  logic [TID_WIDTH-1:0]            s_ar_id,
  output logic                            s_r_valid,
  input  logic                            s_r_ready,
  output logic                            s_r_last,
  output logic [BLOCK_DATA_SIZE_BITS-1:0] s_r_data,
  output logic [TID_WIDTH-1:0]            s_r_id,
  output logic [LOG_REQ_QUEUE:0]          reqCnt
);

  localparam int NREP  = BLOCK_DATA_SIZE_BITS / ADDR_BITS;
  localparam int LAT_W = (RESP_LATENCY < 1) ? 1 : $clog2(RESP_LATENCY + 1);

  typedef struct packed {
    logic [ADDR_BITS-1:0]       addr;
    logic [BURST_LEN_WIDTH-1:0] len;
    logic [TID_WIDTH-1:0]       id;
  } req_t;

  rd_state_t                  state;
  rd_state_t                  state_d;
  logic [LAT_W-1:0]           cnt;
  logic [LAT_W-1:0]           cnt_d;
  logic [BURST_LEN_WIDTH-1:0] beat;
  logic [BURST_LEN_WIDTH-1:0] beat_d;
  logic                       ar_ok;
  req_t                       ar_req;
  req_t                       head;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       in_burst;
  logic                       beat_last;
  logic                       r_hs;
  logic                       more_work;
  logic                       launch;
  logic [ADDR_BITS-1:0]       beat_addr;

  assign ar_req     = {s_ar_addr, s_ar_len, s_ar_id};
  assign s_ar_ready = en & ~full & ar_ok;
  assign push       = s_ar_valid & s_ar_ready;

  axi_req_fifo #(
    .T         (req_t),
    .LOG_DEPTH (LOG_REQ_QUEUE)
  ) u_req_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (push),
    .din    (ar_req),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (reqCnt)
  );

  assign in_burst  = (state == BURST);
  assign beat_last = (beat == head.len);

`ifdef AXI_RD_RESP_STALL_EN
  logic [7:0] lfsr;
  logic       valid_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      lfsr    <= LFSR_SEED;
      valid_q <= 1'b0;
    end else begin
      lfsr    <= lfsr_next(lfsr);
      valid_q <= s_r_valid & ~s_r_ready;
    end
  end

  // A beat already offered stays offered; only a fresh beat may be withheld.
  assign s_r_valid = in_burst & (valid_q | ~lfsr[7]);
`else
  assign s_r_valid = in_burst;
`endif

  assign r_hs      = s_r_valid & s_r_ready;
  assign pop       = r_hs & beat_last;
  assign more_work = (reqCnt > (LOG_REQ_QUEUE+1)'(1)) | push;

  assign beat_addr = head.addr + (ADDR_BITS'(beat) << LOG_BLOCK_DATA_BYTES);
  assign s_r_data  = in_burst ? {NREP{beat_addr}} : '0;
  assign s_r_last  = in_burst & beat_last;
  assign s_r_id    = in_burst ? head.id : '0;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    beat_d  = beat;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        launch = en & (~empty | push);
      end
      WAIT: begin
        if (en) begin
          if (cnt <= LAT_W'(1)) begin
            state_d = BURST;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
      end
      BURST: begin
        if (r_hs) begin
          if (beat_last) begin
            beat_d  = '0;
            state_d = IDLE;
            launch  = en & more_work;
          end else begin
            beat_d = beat + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Launch decision is made at the eligibility edge, so a latency of one
    // skips WAIT entirely and larger latencies preload latency-1.
    if (launch) begin
      if (RESP_LATENCY <= 1) begin
        state_d = BURST;
      end else begin
        state_d = WAIT;
        cnt_d   = LAT_W'(RESP_LATENCY - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= '0;
      beat  <= '0;
      ar_ok <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      beat  <= beat_d;
      ar_ok <= 1'b1;
    end
  end

endmodule
